// File: rtl/xinyi_trace_pkg.sv
// xinyi_trace_pkg: shared trace entry type and write-enable constant for the debug writeback trace
package xinyi_trace_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_trace_t;
  localparam logic [3:0] WB_WEN_ALL = 4'hf;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: 2-write/1-read FIFO of trace entries, in0 written before in1
//  clock, reset : core clock, synchronous active-high reset
//  push_cnt     : entries written this cycle (0..2), taken from in0 then in1
//  pop          : consume head this cycle (caller guarantees count != 0)
//  head, count  : oldest entry and current occupancy
module trace_fifo
  import xinyi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               push_cnt,
  input  wb_trace_t                in0,
  input  wb_trace_t                in1,
  input  logic                     pop,
  output wb_trace_t                head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  wb_trace_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (push_cnt != 2'd0) mem[wr_ptr] <= in0;
    if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= in1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push_cnt) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/wb_trace_serializer.sv
// wb_trace_serializer: buffers dual-issue writebacks and drains them as an ordered debug_wb_* stream
//  clock, reset        : core clock, synchronous active-high reset
//  wb0_*/wb1_*         : per-slot retire channels, slot 1 is program-order younger
//  stall               : fewer than two free FIFO entries
//  debug_wb_*          : one emitted write per cycle; pc holds last emitted value
//  inst_cnt            : retired instructions, traced or not
//  overflow_err        : sticky, set when an eligible write was dropped
module wb_trace_serializer
  import xinyi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb0_valid,
  input  logic        wb0_wen,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_valid,
  input  logic        wb1_wen,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb1_pc,
  output logic        stall,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] inst_cnt,
  output logic        overflow_err
);
  localparam int AW = $clog2(DEPTH);
  logic          e0;
  logic          e1;
  wb_trace_t     s0;
  wb_trace_t     s1;
  wb_trace_t     in0;
  wb_trace_t     head;
  logic [1:0]    push_cnt;
  logic          pop;
  logic [AW:0]   count;
  always_comb begin
    e0       = wb0_valid && wb0_wen && wb0_rd != 5'd0;
    e1       = wb1_valid && wb1_wen && wb1_rd != 5'd0;
    s0       = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
    s1       = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};
    stall    = ((AW+1)'(DEPTH) - count) < (AW+1)'(2);
    // a lone eligible slot 1 is compacted into the first write port
    in0      = e0 ? s0 : s1;
    push_cnt = stall ? 2'd0 : {1'b0, e0} + {1'b0, e1};
    pop      = count != '0;
  end
  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_cnt (push_cnt),
    .in0      (in0),
    .in1      (s1),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      inst_cnt          <= '0;
      overflow_err      <= 1'b0;
    end else begin
      debug_wb_rf_wen   <= pop ? WB_WEN_ALL : 4'h0;
      debug_wb_rf_wnum  <= pop ? head.rd : 5'd0;
      debug_wb_rf_wdata <= pop ? head.wdata : 32'd0;
      if (pop) debug_wb_pc <= head.pc;
      inst_cnt          <= inst_cnt + 32'(wb0_valid) + 32'(wb1_valid);
      overflow_err      <= overflow_err | (stall & (e0 | e1));
    end
  end
endmodule

// File: tb/tb_wb_trace_serializer.sv
// tb_wb_trace_serializer: directed self-checking bench for wb_trace_serializer
module tb_wb_trace_serializer;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb0_wen, wb1_valid, wb1_wen;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_wdata, wb0_pc, wb1_wdata, wb1_pc;
  logic        stall;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] inst_cnt;
  logic        overflow_err;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_cnt;
  typedef struct {
    logic [3:0]  wen;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] d;
    int          c;
  } em_t;
  em_t cap[$];
  em_t ex[$];
  always #5 clk = ~clk;
  wb_trace_serializer #(.DEPTH(8)) dut (
    .clock             (clk),
    .reset             (reset),
    .wb0_valid         (wb0_valid),
    .wb0_wen           (wb0_wen),
    .wb0_rd            (wb0_rd),
    .wb0_wdata         (wb0_wdata),
    .wb0_pc            (wb0_pc),
    .wb1_valid         (wb1_valid),
    .wb1_wen           (wb1_wen),
    .wb1_rd            (wb1_rd),
    .wb1_wdata         (wb1_wdata),
    .wb1_pc            (wb1_pc),
    .stall             (stall),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .inst_cnt          (inst_cnt),
    .overflow_err      (overflow_err)
  );
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (debug_wb_rf_wen != 4'h0)
      cap.push_back('{wen: debug_wb_rf_wen, pc: debug_wb_pc, rd: debug_wb_rf_wnum, d: debug_wb_rf_wdata, c: cyc});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {wb0_valid, wb0_wen, wb0_rd, wb0_wdata, wb0_pc} = '0;
    {wb1_valid, wb1_wen, wb1_rd, wb1_wdata, wb1_pc} = '0;
  endtask
  task automatic drive(input logic v0, input logic w0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
                       input logic v1, input logic w1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1);
    {wb0_valid, wb0_wen, wb0_rd, wb0_wdata, wb0_pc} = {v0, w0, r0, d0, p0};
    {wb1_valid, wb1_wen, wb1_rd, wb1_wdata, wb1_pc} = {v1, w1, r1, d1, p1};
    exp_cnt = exp_cnt + 32'(v0) + 32'(v1);
    step();
    idle();
  endtask
  task automatic want(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
    ex.push_back('{wen: 4'hf, pc: pc, rd: rd, d: d, c: 0});
  endtask
  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_count"}, 64'(cap.size()), 64'(ex.size()));
    n = (cap.size() < ex.size()) ? cap.size() : ex.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_pc%0d", tag, i), 64'(cap[i].pc), 64'(ex[i].pc));
      chk($sformatf("%s_rd%0d", tag, i), 64'(cap[i].rd), 64'(ex[i].rd));
      chk($sformatf("%s_d%0d", tag, i), 64'(cap[i].d), 64'(ex[i].d));
      chk($sformatf("%s_wen%0d", tag, i), 64'(cap[i].wen), 64'hf);
      chk($sformatf("%s_gap%0d", tag, i), 64'(cap[i].c - cap[0].c), 64'(i));
    end
    cap.delete();
    ex.delete();
  endtask
  initial begin
    exp_cnt = 0;
    reset = 1'b1;
    idle();
    repeat (3) step();
    reset = 1'b0;
    chk("rst_wen", 64'(debug_wb_rf_wen), 64'h0);
    chk("rst_pc", 64'(debug_wb_pc), 64'h0);
    chk("rst_wnum", 64'(debug_wb_rf_wnum), 64'h0);
    chk("rst_wdata", 64'(debug_wb_rf_wdata), 64'h0);
    chk("rst_cnt", 64'(inst_cnt), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_ovf", 64'(overflow_err), 64'h0);
    step();
    cap.delete();
    drive(1, 1, 5'd1, 32'h11, 32'hbfc00000, 1, 1, 5'd2, 32'h22, 32'hbfc00004);
    chk("t2_n1_wen", 64'(debug_wb_rf_wen), 64'h0);
    step();
    chk("t2_n2_wen", 64'(debug_wb_rf_wen), 64'hf);
    chk("t2_n2_wnum", 64'(debug_wb_rf_wnum), 64'd1);
    chk("t2_n2_wdata", 64'(debug_wb_rf_wdata), 64'h11);
    chk("t2_n2_pc", 64'(debug_wb_pc), 64'hbfc00000);
    step();
    chk("t2_n3_wen", 64'(debug_wb_rf_wen), 64'hf);
    chk("t2_n3_wnum", 64'(debug_wb_rf_wnum), 64'd2);
    chk("t2_n3_wdata", 64'(debug_wb_rf_wdata), 64'h22);
    chk("t2_n3_pc", 64'(debug_wb_pc), 64'hbfc00004);
    step();
    chk("t2_idle_wen", 64'(debug_wb_rf_wen), 64'h0);
    chk("t2_idle_wnum", 64'(debug_wb_rf_wnum), 64'h0);
    chk("t2_idle_wdata", 64'(debug_wb_rf_wdata), 64'h0);
    chk("t2_idle_pc", 64'(debug_wb_pc), 64'hbfc00004);
    chk("t2_cnt", 64'(inst_cnt), 64'd2);
    cap.delete();
    drive(1, 1, 5'd0, 32'h33, 32'h100, 1, 0, 5'd3, 32'h44, 32'h104);
    repeat (4) step();
    chk("t3_emits", 64'(cap.size()), 64'd0);
    chk("t3_cnt", 64'(inst_cnt), 64'(exp_cnt));
    cap.delete();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_stall%0d", i), 64'(stall), 64'h0);
      drive(1, 1, 5'(i + 1), 32'ha000 + 32'(i), 32'h1000 + 32'(8 * i),
            1, 1, 5'(i + 9), 32'hb000 + 32'(i), 32'h1004 + 32'(8 * i));
      want(32'h1000 + 32'(8 * i), 5'(i + 1), 32'ha000 + 32'(i));
      want(32'h1004 + 32'(8 * i), 5'(i + 9), 32'hb000 + 32'(i));
    end
    repeat (10) step();
    cmp_stream("t4");
    chk("t4_ovf", 64'(overflow_err), 64'h0);
    chk("t4_cnt", 64'(inst_cnt), 64'(exp_cnt));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_stall%0d", i), 64'(stall), 64'h0);
      drive(1, 1, 5'(i + 1), 32'hc000 + 32'(i), 32'h2000 + 32'(8 * i),
            1, 1, 5'(i + 17), 32'hd000 + 32'(i), 32'h2004 + 32'(8 * i));
      want(32'h2000 + 32'(8 * i), 5'(i + 1), 32'hc000 + 32'(i));
      want(32'h2004 + 32'(8 * i), 5'(i + 17), 32'hd000 + 32'(i));
    end
    chk("t5_stalled", 64'(stall), 64'h1);
    chk("t5_count7", 64'(dut.u_fifo.count), 64'd7);
    drive(1, 1, 5'd30, 32'hdead, 32'hdead0000, 1, 1, 5'd31, 32'hbeef, 32'hdead0004);
    chk("t5_ovf_set", 64'(overflow_err), 64'h1);
    repeat (16) step();
    chk("t5_ovf_sticky", 64'(overflow_err), 64'h1);
    chk("t5_unstall", 64'(stall), 64'h0);
    chk("t5_cnt", 64'(inst_cnt), 64'(exp_cnt));
    cmp_stream("t5");
    drive(1, 1, 5'd1, 32'h1, 32'h3000, 1, 1, 5'd2, 32'h2, 32'h3004);
    drive(1, 1, 5'd3, 32'h3, 32'h3008, 1, 1, 5'd4, 32'h4, 32'h300c);
    drive(1, 1, 5'd5, 32'h5, 32'h3010, 0, 0, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = 0;
    chk("t6_wen", 64'(debug_wb_rf_wen), 64'h0);
    chk("t6_count", 64'(dut.u_fifo.count), 64'd0);
    chk("t6_cnt", 64'(inst_cnt), 64'd0);
    chk("t6_ovf", 64'(overflow_err), 64'h0);
    chk("t6_pc", 64'(debug_wb_pc), 64'h0);
    cap.delete();
    drive(0, 0, 5'd0, 32'h0, 32'h0, 1, 1, 5'd7, 32'h77, 32'h4000);
    chk("t6_n1_wen", 64'(debug_wb_rf_wen), 64'h0);
    step();
    chk("t6_n2_wen", 64'(debug_wb_rf_wen), 64'hf);
    chk("t6_n2_wnum", 64'(debug_wb_rf_wnum), 64'd7);
    chk("t6_n2_wdata", 64'(debug_wb_rf_wdata), 64'h77);
    chk("t6_n2_pc", 64'(debug_wb_pc), 64'h4000);
    step();
    chk("t6_n3_wen", 64'(debug_wb_rf_wen), 64'h0);
    chk("t6_n3_cnt", 64'(inst_cnt), 64'd1);
    repeat (4) step();
    chk("t6_emits", 64'(cap.size()), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
